hazard_ctrl_mc: RTL and testbench
=================================

HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, meaning multi-cycle (mul/div) E-stage occupancy in cycles, legal 1..16.
REQ-002 SHALL have parameter LOAD_BUBBLES, default 1, meaning load-use bubbles inserted, legal 1..2.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of performance counters.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 CpuRstN  in  1  reset, synchronous, active-low.
REQ-006 ICacheMiss, DCacheMiss  in  1 each  cache miss pending.
REQ-007 BranchE, JalrE, JalD  in  1 each  control transfer taken.
REQ-008 Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register numbers.
REQ-009 RegReadE  in  2  [1]=rs1 used, [0]=rs2 used in E.
REQ-010 RegWriteM, RegWriteW  in  3 each  nonzero = writes Rd.
REQ-011 MemToRegE, MemToRegM  in  1 each  load in E / M.
REQ-012 MulDivE  in  1  multi-cycle op in E.
REQ-013 StallF..StallW, FlushF..FlushW  out  1 each  per-stage hold / clear.
REQ-014 Forward1E, Forward2E  out  2 each  00 regfile, 01 W data, 10 M ALU result.
REQ-015 MdDone  out  1  multi-cycle result valid this cycle.
REQ-016 StallCycles, CtrlFlushes  out  CNT_W each  performance counters.

Function
REQ-017 Stall/flush priority SHALL be: reset > cache miss > MD busy > BranchE|JalrE > JalD > load-use > none.
REQ-018 Reset active: all Flush=1, all Stall=0, Forward=00, MdDone=0.
REQ-019 Cache miss: all Stall=1, all Flush=0; FSM state and MD counter frozen.
REQ-020 BranchE|JalrE: FlushD=FlushE=1, others 0; JalD: FlushD=1 only.
REQ-021 Load-use: StallF=StallD=1, FlushE=1 when MemToRegE, RdE!=0, RdE matches Rs1D or Rs2D; with LOAD_BUBBLES=2 also when MemToRegM, RdM!=0, RdM matches Rs1D or Rs2D.
REQ-022 FSM states IDLE, MD_WAIT; 4-bit-min down-counter MdCnt.
REQ-023 IDLE & MulDivE & MD_LAT>1 & no miss: StallF=StallD=StallE=1, FlushM=1, MdCnt<=MD_LAT-2, go MD_WAIT.
REQ-024 MD_WAIT & MdCnt!=0 & no miss: same stall/flush as REQ-023, MdCnt decrements.
REQ-025 MD_WAIT & MdCnt==0 & no miss: MdDone=1, no MD stall, lower priorities apply, go IDLE; MulDivE this cycle SHALL NOT restart.
REQ-026 MD_LAT=1: MulDivE in IDLE gives MdDone=1 same cycle, no stall, stays IDLE.
REQ-027 Total E occupancy of a multi-cycle op SHALL equal MD_LAT cycles excluding miss-stall cycles.
REQ-028 Forward1E=10 when RegWriteM!=0, RegReadE[1], RdM==Rs1E, RdM!=0, and not (MemToRegM with LOAD_BUBBLES=1); else 01 when RegWriteW!=0, RegReadE[1], RdW==Rs1E, RdW!=0; else 00. Forward2E same with RegReadE[0], Rs2E.
REQ-029 Forward outputs SHALL be combinational, independent of stall state.
REQ-030 StallCycles SHALL increment each non-reset cycle StallF=1; CtrlFlushes each cycle REQ-020 applies; both saturate at all-ones.

Reset
REQ-031 CpuRstN low at a Clk edge: state IDLE, MdCnt 0, both counters 0.
REQ-032 Reset mid-MD_WAIT SHALL abort the op; no MdDone after release.
REQ-033 Outputs of REQ-018 SHALL follow CpuRstN combinationally.

Structure
REQ-034 FSM state encoding, Forward codes (00/01/10) and stall/flush vector ordering SHALL live in shared package hazard_pkg.
REQ-035 Forward-select logic SHALL be one sub-module fwd_sel, instantiated twice.

Verification
REQ-036 MD_LAT=4, MulDivE high 4 cycles from IDLE -> StallF/D/E=1 cycles 0-2, MdDone=1 cycle 3, IDLE cycle 4.
REQ-037 MD_LAT=4, DCacheMiss for 2 cycles at cycle 1 of op -> MdDone at cycle 5, all stages stalled cycles 1-2.
REQ-038 LOAD_BUBBLES=2, load x5 then add x6,x5,x5 -> 2 bubbles, Forward1E=01 on add's E cycle.
REQ-039 BranchE=1 with MemToRegE load-use same cycle -> FlushD=FlushE=1, StallF=0, CtrlFlushes +1.
REQ-040 RdM=RdW=0, RegWriteM=RegWriteW=1, Rs1E=0 -> Forward1E=00.
REQ-041 CpuRstN low during MD_WAIT MdCnt=1 -> all Flush=1, IDLE, counters 0, no MdDone.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: MD FSM state encoding,
// forwarding select codes and the bit ordering of the per-stage vectors.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    // Stage bit positions inside stall/flush vectors, fetch at bit 0.
    localparam int STG_F   = 0;
    localparam int STG_D   = 1;
    localparam int STG_E   = 2;
    localparam int STG_M   = 3;
    localparam int STG_W   = 4;
    localparam int NUM_STG = 5;

    typedef logic [NUM_STG-1:0] stage_vec_t;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// Operand forwarding selector for one E-stage source operand.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic       used,
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [2:0] reg_write_m,
    input  logic       mem_to_reg_m,
    input  logic [4:0] rd_w,
    input  logic [2:0] reg_write_w,
    output fwd_t       sel
);

    // A load in M has no ALU result worth forwarding unless the second
    // bubble was inserted; in that case M is already past the load data.
    always_comb begin
        sel = FWD_RF;
        if ((reg_write_m != 3'd0) && used && reg_match(rd_m, rs) &&
            !(mem_to_reg_m && (LOAD_BUBBLES == 1))) begin
            sel = FWD_M;
        end else if ((reg_write_w != 3'd0) && used && reg_match(rd_w, rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: stall/flush arbitration, multi-cycle
// mul/div occupancy tracking, operand forwarding and perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int MD_LAT       = 4,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             CpuRstN,
    input  logic             ICacheMiss,
    input  logic             DCacheMiss,
    input  logic             BranchE,
    input  logic             JalrE,
    input  logic             JalD,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       RegReadE,
    input  logic [2:0]       RegWriteM,
    input  logic [2:0]       RegWriteW,
    input  logic             MemToRegE,
    input  logic             MemToRegM,
    input  logic             MulDivE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushF,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       Forward1E,
    output logic [1:0]       Forward2E,
    output logic             MdDone,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] CtrlFlushes
);

    // First cycle of an op is spent in IDLE, last with the counter at zero.
    localparam logic [3:0] MD_START = 4'((MD_LAT > 1) ? (MD_LAT - 2) : 0);

    md_state_t        state_reg;
    logic [3:0]       md_cnt_reg;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] ctrl_flushes_reg;

    logic       miss;
    logic       md_start;
    logic       md_busy;
    logic       md_done;
    logic       load_use;
    logic       ctrl_flush;
    stage_vec_t stall_vec;
    stage_vec_t flush_vec;
    fwd_t       fwd1;
    fwd_t       fwd2;

    assign miss     = ICacheMiss | DCacheMiss;
    assign md_start = (state_reg == ST_IDLE) && MulDivE && (MD_LAT > 1);
    assign md_busy  = !miss && (md_start || ((state_reg == ST_MD_WAIT) && (md_cnt_reg != 4'd0)));
    assign md_done  = !miss && (((state_reg == ST_MD_WAIT) && (md_cnt_reg == 4'd0)) ||
                                ((state_reg == ST_IDLE) && MulDivE && (MD_LAT == 1)));

    assign load_use = (MemToRegE && (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D))) ||
                      ((LOAD_BUBBLES == 2) && MemToRegM &&
                       (reg_match(RdM, Rs1D) || reg_match(RdM, Rs2D)));

    // Priority arbitration of per-stage stall and flush requests.
    always_comb begin
        stall_vec  = '0;
        flush_vec  = '0;
        ctrl_flush = 1'b0;
        if (!CpuRstN) begin
            flush_vec = '1;
        end else if (miss) begin
            stall_vec = '1;
        end else if (md_busy) begin
            stall_vec[STG_F] = 1'b1;
            stall_vec[STG_D] = 1'b1;
            stall_vec[STG_E] = 1'b1;
            flush_vec[STG_M] = 1'b1;
        end else if (BranchE || JalrE) begin
            flush_vec[STG_D] = 1'b1;
            flush_vec[STG_E] = 1'b1;
            ctrl_flush       = 1'b1;
        end else if (JalD) begin
            flush_vec[STG_D] = 1'b1;
            ctrl_flush       = 1'b1;
        end else if (load_use) begin
            stall_vec[STG_F] = 1'b1;
            stall_vec[STG_D] = 1'b1;
            flush_vec[STG_E] = 1'b1;
        end
    end

    assign StallF = stall_vec[STG_F];
    assign StallD = stall_vec[STG_D];
    assign StallE = stall_vec[STG_E];
    assign StallM = stall_vec[STG_M];
    assign StallW = stall_vec[STG_W];
    assign FlushF = flush_vec[STG_F];
    assign FlushD = flush_vec[STG_D];
    assign FlushE = flush_vec[STG_E];
    assign FlushM = flush_vec[STG_M];
    assign FlushW = flush_vec[STG_W];

    assign MdDone = CpuRstN && md_done;

    fwd_sel #(.LOAD_BUBBLES(LOAD_BUBBLES)) u_fwd1 (
        .used         (RegReadE[1]),
        .rs           (Rs1E),
        .rd_m         (RdM),
        .reg_write_m  (RegWriteM),
        .mem_to_reg_m (MemToRegM),
        .rd_w         (RdW),
        .reg_write_w  (RegWriteW),
        .sel          (fwd1)
    );

    fwd_sel #(.LOAD_BUBBLES(LOAD_BUBBLES)) u_fwd2 (
        .used         (RegReadE[0]),
        .rs           (Rs2E),
        .rd_m         (RdM),
        .reg_write_m  (RegWriteM),
        .mem_to_reg_m (MemToRegM),
        .rd_w         (RdW),
        .reg_write_w  (RegWriteW),
        .sel          (fwd2)
    );

    assign Forward1E = CpuRstN ? fwd1 : FWD_RF;
    assign Forward2E = CpuRstN ? fwd2 : FWD_RF;

    // Multi-cycle op FSM; a cache miss freezes both state and counter.
    always_ff @(posedge Clk) begin
        if (!CpuRstN) begin
            state_reg  <= ST_IDLE;
            md_cnt_reg <= 4'd0;
        end else if (!miss) begin
            case (state_reg)
                ST_IDLE: begin
                    if (md_start) begin
                        state_reg  <= ST_MD_WAIT;
                        md_cnt_reg <= MD_START;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_cnt_reg != 4'd0) begin
                        md_cnt_reg <= md_cnt_reg - 4'd1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    md_cnt_reg <= 4'd0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge Clk) begin
        if (!CpuRstN) begin
            stall_cycles_reg <= '0;
            ctrl_flushes_reg <= '0;
        end else begin
            if (stall_vec[STG_F] && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (ctrl_flush && (ctrl_flushes_reg != '1)) begin
                ctrl_flushes_reg <= ctrl_flushes_reg + 1'b1;
            end
        end
    end

    assign StallCycles = stall_cycles_reg;
    assign CtrlFlushes = ctrl_flushes_reg;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench: two instances (defaults, and MD_LAT=1/LOAD_BUBBLES=2/
// CNT_W=4) share stimulus and are compared against a behavioural model.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       CpuRstN, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] RegReadE;
    logic [2:0] RegWriteM, RegWriteW;
    logic       MemToRegE, MemToRegM, MulDivE;

    logic [4:0]  st0, fl0, st1, fl1;
    logic [1:0]  f10, f20, f11, f21;
    logic        md0, md1;
    logic [31:0] sc0, cf0;
    logic [3:0]  sc1, cf1;
    logic [14:0] obs0, obs1;

    assign obs0 = {st0, fl0, f10, f20, md0};
    assign obs1 = {st1, fl1, f11, f21, md1};

    always #5 clk = ~clk;

    hazard_ctrl_mc dut (
        .Clk(clk), .CpuRstN(CpuRstN), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MulDivE(MulDivE),
        .StallF(st0[0]), .StallD(st0[1]), .StallE(st0[2]), .StallM(st0[3]), .StallW(st0[4]),
        .FlushF(fl0[0]), .FlushD(fl0[1]), .FlushE(fl0[2]), .FlushM(fl0[3]), .FlushW(fl0[4]),
        .Forward1E(f10), .Forward2E(f20), .MdDone(md0), .StallCycles(sc0), .CtrlFlushes(cf0)
    );

    hazard_ctrl_mc #(.MD_LAT(1), .LOAD_BUBBLES(2), .CNT_W(4)) dut2 (
        .Clk(clk), .CpuRstN(CpuRstN), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegReadE(RegReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .MulDivE(MulDivE),
        .StallF(st1[0]), .StallD(st1[1]), .StallE(st1[2]), .StallM(st1[3]), .StallW(st1[4]),
        .FlushF(fl1[0]), .FlushD(fl1[1]), .FlushE(fl1[2]), .FlushM(fl1[3]), .FlushW(fl1[4]),
        .Forward1E(f11), .Forward2E(f21), .MdDone(md1), .StallCycles(sc1), .CtrlFlushes(cf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model configuration and state, one slot per instance.
    int     lat[2]  = '{4, 1};
    int     lb[2]   = '{1, 2};
    int     cwid[2] = '{32, 4};
    bit     act[2];
    int     k[2];
    longint scnt[2];
    longint fcnt[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic used, input logic [4:0] rs, input int lbub);
        if (RegWriteM != 0 && used && RdM == rs && RdM != 0 && !(MemToRegM && lbub == 1))
            return 2'b10;
        if (RegWriteW != 0 && used && RdW == rs && RdW != 0)
            return 2'b01;
        return 2'b00;
    endfunction

    // Occupancy model: k counts the op's completed non-miss E cycles; the op
    // holds the pipeline until its final (MD_LAT-th) cycle.
    task automatic model_cycle(input int i, output logic [14:0] e);
        logic [4:0] st, fl;
        logic [1:0] a, b;
        bit miss, busy, done, lu, ctrl;
        longint maxv;
        st = 0; fl = 0; a = 0; b = 0;
        busy = 0; done = 0; ctrl = 0;
        miss = ICacheMiss || DCacheMiss;
        maxv = (longint'(1) << cwid[i]) - 1;
        if (!CpuRstN) begin
            fl = 5'h1f;
            act[i] = 0; k[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end else begin
            if (!miss) begin
                if (act[i]) begin
                    if (k[i] < lat[i] - 1) begin busy = 1; k[i]++; end
                    else begin done = 1; act[i] = 0; end
                end else if (MulDivE) begin
                    if (lat[i] > 1) begin busy = 1; act[i] = 1; k[i] = 1; end
                    else done = 1;
                end
            end
            lu = (MemToRegE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) ||
                 (lb[i] == 2 && MemToRegM && RdM != 0 && (RdM == Rs1D || RdM == Rs2D));
            if (miss) st = 5'h1f;
            else if (busy) begin st = 5'b00111; fl = 5'b01000; end
            else if (BranchE || JalrE) begin fl = 5'b00110; ctrl = 1; end
            else if (JalD) begin fl = 5'b00010; ctrl = 1; end
            else if (lu) begin st = 5'b00011; fl = 5'b00100; end
            a = fwd_model(RegReadE[1], Rs1E, lb[i]);
            b = fwd_model(RegReadE[0], Rs2E, lb[i]);
            if (st[0] && scnt[i] < maxv) scnt[i]++;
            if (ctrl && fcnt[i] < maxv) fcnt[i]++;
        end
        e = {st, fl, a, b, logic'(done)};
    endtask

    // Called with inputs already driven after a falling edge.
    task automatic run_cycle(input string tag);
        logic [14:0] e0, e1;
        #1;
        chk({tag, ".sc0"}, sc0, scnt[0]);
        chk({tag, ".cf0"}, cf0, fcnt[0]);
        chk({tag, ".sc1"}, sc1, scnt[1]);
        chk({tag, ".cf1"}, cf1, fcnt[1]);
        model_cycle(0, e0);
        model_cycle(1, e1);
        chk({tag, ".out0"}, obs0, e0);
        chk({tag, ".out1"}, obs1, e1);
        @(negedge clk);
    endtask

    task automatic clr_in();
        CpuRstN = 1; ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegReadE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; MemToRegM = 0; MulDivE = 0;
    endtask

    initial begin
        clr_in();
        @(negedge clk);

        // Reset: all flush, nothing else.
        CpuRstN = 0; MulDivE = 1; BranchE = 1;
        #1 chk("rst_out", obs0, 15'b00000_11111_00_00_0);
        run_cycle("rst0");
        run_cycle("rst1");

        // Four-cycle mul/div from IDLE.
        clr_in();
        for (int c = 0; c < 5; c++) begin
            MulDivE = (c < 4);
            #1;
            if (c < 3) begin
                chk("md_stall", st0[2:0], 3'b111);
                chk("md_nodone", md0, 1'b0);
            end else if (c == 3) begin
                chk("md_done", md0, 1'b1);
                chk("md_done_nostall", st0[0], 1'b0);
            end else begin
                chk("md_idle", {st0, md0}, 6'b0);
            end
            run_cycle("md4");
        end

        // Cache miss in the middle of a mul/div stretches it by two cycles.
        clr_in();
        for (int c = 0; c < 7; c++) begin
            MulDivE = (c <= 5);
            DCacheMiss = (c == 1 || c == 2);
            #1;
            if (c == 1 || c == 2) chk("miss_stall", {st0, fl0}, 10'b11111_00000);
            chk("miss_mddone", md0, logic'(c == 5));
            run_cycle("mdmiss");
        end

        // Load x5 then add x6,x5,x5 with two load-use bubbles.
        clr_in();
        MemToRegE = 1; RdE = 5; Rs1D = 5; Rs2D = 5;
        #1 chk("lu2_a", {st1[1:0], fl1[2]}, 3'b111);
        run_cycle("lu2a");
        MemToRegE = 0; RdE = 0; MemToRegM = 1; RdM = 5; RegWriteM = 1;
        #1 chk("lu2_b", {st1[1:0], fl1[2]}, 3'b111);
        chk("lu1_b", st0[1:0], 2'b00);
        run_cycle("lu2b");
        MemToRegM = 0; RdM = 0; RegWriteM = 0; RdW = 5; RegWriteW = 1;
        Rs1D = 0; Rs2D = 0; Rs1E = 5; Rs2E = 5; RegReadE = 2'b11;
        #1 chk("lu2_fwd", f11, 2'b01);
        chk("lu2_nostall", st1, 5'b0);
        run_cycle("lu2c");

        // Branch wins over a simultaneous load-use.
        clr_in();
        CpuRstN = 0;
        run_cycle("rst2");
        CpuRstN = 1; BranchE = 1; MemToRegE = 1; RdE = 3; Rs1D = 3;
        #1 chk("br_flush", fl0, 5'b00110);
        chk("br_nostall", st0[0], 1'b0);
        chk("br_cnt_pre", cf0, 32'd0);
        run_cycle("br");
        clr_in();
        #1 chk("br_cnt_post", cf0, 32'd1);
        run_cycle("br2");

        // x0 never forwards.
        RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0; RegReadE = 2'b11;
        #1 chk("x0_fwd0", f10, 2'b00);
        chk("x0_fwd1", f11, 2'b00);
        run_cycle("x0");

        // Reset while MdCnt==1 aborts the op.
        clr_in();
        MulDivE = 1;
        run_cycle("ab0");
        run_cycle("ab1");
        CpuRstN = 0;
        #1 chk("ab_rst", {st0, fl0, md0}, 11'b00000_11111_0);
        run_cycle("ab2");
        CpuRstN = 1; MulDivE = 0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("ab_after", {st0, md0, sc0, cf0}, 70'd0);
            run_cycle("ab3");
        end

        // Saturation of the 4-bit counters.
        ICacheMiss = 1;
        for (int c = 0; c < 20; c++) run_cycle("sat");
        clr_in();
        #1 chk("sat_sc1", sc1, 4'hf);
        run_cycle("sat2");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            CpuRstN    = ($urandom_range(0, 63) != 0);
            ICacheMiss = ($urandom_range(0, 15) == 0);
            DCacheMiss = ($urandom_range(0, 15) == 0);
            BranchE    = ($urandom_range(0, 7) == 0);
            JalrE      = ($urandom_range(0, 15) == 0);
            JalD       = ($urandom_range(0, 7) == 0);
            MulDivE    = ($urandom_range(0, 5) == 0);
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegReadE  = 2'($urandom_range(0, 3));
            RegWriteM = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            RegWriteW = $urandom_range(0, 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            MemToRegE = ($urandom_range(0, 2) == 0);
            MemToRegM = ($urandom_range(0, 2) == 0);
            run_cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
